id_token_collector: RTL and testbench

- Sits directly downstream of the identifier-recognition FSM.
- Consumes the same 8-bit character stream plus the FSM's registered per-character hit bit (`id_hit`).
- Segments the stream into identifier tokens and measures each token's length and digit count.
- Queues one record per completed token in a small first-word-fall-through FIFO, read out through a valid/ready interface; also keeps token and drop statistics.

---
 rtl/id_token_collector.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_id_token_collector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_token_collector.sv
// ---------------------------------------------------------------------------
// id_token_collector
//
// Purpose:
//   Sits behind the identifier-recognition FSM. It watches the same 8-bit
//   character stream together with the FSM's registered per-character hit
//   bit and splits the stream into identifier tokens. An identifier starts at
//   the first letter of a run and ends at the next separator. Leading digits
//   before that letter are not part of the token.
//   For each completed token it queues {length, digit count} in a small
//   first-word-fall-through FIFO. The FIFO is read through a valid/ready
//   handshake. The block also keeps a token counter and a drop counter.
//
// Optional feature:
//   `ID_TOKEN_CHECK_EN` adds a sticky cross-check between the character class
//   and the upstream id_hit bit, reported on err. When the macro is not
//   defined, err is tied low.
//
// Parameters:
//   FIFO_DEPTH  record FIFO entries. Must be a power of 2 and at least 2.
//   LEN_W       width of the length and digit-count fields.
//
// Ports:
//   clk         rising-edge clock, one character per cycle
//   rst_n       asynchronous active-low reset
//   char        ASCII character, the same signal that feeds the upstream FSM
//   id_hit      upstream FSM hit, registered on the same edge as char
//   out_valid   FIFO head record is valid
//   out_ready   consumer accepts the head when high together with out_valid
//   out_len     head record token length, saturating
//   out_digits  head record digit count (id_hit cycles in token), saturating
//   tok_count   tokens completed, including dropped ones; wraps
//   drop_count  records lost to a full FIFO; saturates at 255
//   overflow    sticky, set by the first drop
//   err         sticky class/id_hit cross-check error
// ---------------------------------------------------------------------------
module id_token_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             id_hit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] out_len,
    output logic [LEN_W-1:0] out_digits,
    output logic [15:0]      tok_count,
    output logic [7:0]       drop_count,
    output logic             overflow,
    output logic             err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int REC_W = 2 * LEN_W;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [PTR_W:0]   PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NUM   = 2'd1,
        S_IDENT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Character classification helpers
    // ------------------------------------------------------------------
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_MAX) ? LEN_MAX : v + LEN_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [7:0]       char_d_q, char_d_d;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] dig_q, dig_d;
    logic             push_s;

    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [REC_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             empty_s, full_s, pop_s, accept_s, drop_s;

    logic [15:0]      tok_count_q, tok_count_d;
    logic [7:0]       drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;

    logic             cur_dig_s, cur_let_s;

    // char_d lines the character up with the registered id_hit of the same character
    assign char_d_d  = char;
    assign cur_dig_s = is_digit(char_d_q);
    assign cur_let_s = is_letter(char_d_q);

    // ------------------------------------------------------------------
    // Token segmentation FSM
    // ------------------------------------------------------------------
    // Next-state and token counters from the aligned (char_d, id_hit) pair
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        dig_d   = dig_q;
        push_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cur_let_s) begin
                    state_d = S_IDENT;
                    len_d   = LEN_ONE;
                    dig_d   = LEN_ZERO;
                end else if (cur_dig_s) begin
                    state_d = S_NUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NUM: begin
                // A digit run only becomes a token once a letter shows up
                if (cur_let_s) begin
                    state_d = S_IDENT;
                    len_d   = LEN_ONE;
                    dig_d   = LEN_ZERO;
                end else if (cur_dig_s) begin
                    state_d = S_NUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDENT: begin
                if (cur_let_s) begin
                    len_d = sat_inc(len_q);
                end else if (cur_dig_s) begin
                    len_d = sat_inc(len_q);
                    if (id_hit) begin
                        dig_d = sat_inc(dig_q);
                    end else begin
                        dig_d = dig_q;
                    end
                end else begin
                    push_s  = 1'b1;
                    state_d = S_IDLE;
                    len_d   = LEN_ZERO;
                    dig_d   = LEN_ZERO;
                end
            end
            default: begin
                state_d = S_IDLE;
                len_d   = LEN_ZERO;
                dig_d   = LEN_ZERO;
            end
        endcase
    end

    // FSM state, alignment register and token counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_d_q <= 8'h00;
            state_q  <= S_IDLE;
            len_q    <= LEN_ZERO;
            dig_q    <= LEN_ZERO;
        end else begin
            char_d_q <= char_d_d;
            state_q  <= state_d;
            len_q    <= len_d;
            dig_q    <= dig_d;
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    // The pointers have one extra wrap bit so that full and empty can be told apart
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_s   = !empty_s && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign accept_s = push_s && (!full_s || pop_s);
    assign drop_s   = push_s && full_s && !pop_s;

    // FIFO storage and pointer updates
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept_s) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = {len_q, dig_q};
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO registers; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {REC_W{1'b0}};
            end
            wr_ptr_q <= {(PTR_W+1){1'b0}};
            rd_ptr_q <= {(PTR_W+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The head is read straight from storage flops; a push into an empty FIFO appears after the edge
    assign out_valid  = !empty_s;
    assign out_len    = mem_q[rd_ptr_q[PTR_W-1:0]][REC_W-1:LEN_W];
    assign out_digits = mem_q[rd_ptr_q[PTR_W-1:0]][LEN_W-1:0];

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    // Token counter wraps; the drop counter saturates; overflow is sticky
    always_comb begin
        tok_count_d  = tok_count_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (push_s) begin
            tok_count_d = tok_count_q + 16'd1;
        end else begin
            tok_count_d = tok_count_q;
        end
        if (drop_s) begin
            drop_count_d = (drop_count_q == 8'hFF) ? 8'hFF : drop_count_q + 8'd1;
            overflow_d   = 1'b1;
        end else begin
            drop_count_d = drop_count_q;
            overflow_d   = overflow_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_count_q  <= 16'd0;
            drop_count_q <= 8'd0;
            overflow_q   <= 1'b0;
        end else begin
            tok_count_q  <= tok_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tok_count  = tok_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

    // ------------------------------------------------------------------
    // Optional class/id_hit cross-check
    // ------------------------------------------------------------------
`ifdef ID_TOKEN_CHECK_EN
    logic err_q, err_d;

    // Inside an identifier only digits may hit; outside one nothing may hit
    always_comb begin
        err_d = err_q;
        if (state_q == S_IDENT) begin
            if ((cur_dig_s && !id_hit) || (cur_let_s && id_hit)) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else if (id_hit) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_id_token_collector.sv
// ---------------------------------------------------------------------------
// Testbench for id_token_collector.
// Stimulus drives characters, a reference id_hit one cycle behind and a
// consumer ready. A string-level model cuts the stream into segments at
// separators, strips leading digits and computes {len, digits} per token. It
// also tracks FIFO occupancy, drops and statistics. Expected records go into a
// queue. A monitor on the falling edge pops and compares them whenever the DUT
// completes a handshake.
// ---------------------------------------------------------------------------
module tb_id_token_collector;

    localparam int DEPTH = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       char_s = 8'h00;
    logic             id_hit = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [LEN_W-1:0] out_len;
    logic [LEN_W-1:0] out_digits;
    logic [15:0]      tok_count;
    logic [7:0]       drop_count;
    logic             overflow;
    logic             err;

    id_token_collector #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char       (char_s),
        .id_hit     (id_hit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_len    (out_len),
        .out_digits (out_digits),
        .tok_count  (tok_count),
        .drop_count (drop_count),
        .overflow   (overflow),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int dig;
    } rec_t;

    int          n_vec = 0;
    int          n_err = 0;
    rec_t        exp_q[$];
    logic [8:0]  seg_q[$];     // {hit, char} of the current segment
    int          occ = 0;
    int          m_tok = 0;
    int          m_drop = 0;
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;
    logic [7:0]  prev_c = 8'h00;
    bit          prev_h = 1'b0;
    bit          gen_letter = 1'b0;
    int          pops = 0;
    int          last_len = -1;
    int          last_dig = -1;

    function automatic bit is_dig(input logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_let(input logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one processed (char, hit) pair at a rising edge
    task automatic process_pair(input logic [7:0] c, input bit h, input bit rdy);
        bit pop;
        bit in_id;
        int k;
        int len;
        int dig;
        pop   = (occ > 0) && rdy;
        in_id = 1'b0;
        foreach (seg_q[i]) if (is_let(seg_q[i][7:0])) in_id = 1'b1;
`ifdef ID_TOKEN_CHECK_EN
        if (in_id ? ((is_dig(c) && !h) || (is_let(c) && h)) : h) m_err = 1'b1;
`endif
        if (pop) occ--;
        if (is_let(c) || is_dig(c)) begin
            seg_q.push_back({h, c});
        end else begin
            k = 0;
            while (k < seg_q.size() && is_dig(seg_q[k][7:0])) k++;
            if (k < seg_q.size()) begin
                len = seg_q.size() - k;
                dig = 0;
                for (int j = k; j < seg_q.size(); j++) if (seg_q[j][8]) dig++;
                if (len > 255) len = 255;
                if (dig > 255) dig = 255;
                m_tok = (m_tok + 1) % 65536;
                if (occ < DEPTH) begin
                    exp_q.push_back('{len: len, dig: dig});
                    occ++;
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            seg_q.delete();
        end
    endtask

    // One character cycle; entered and left at posedge+1
    task automatic step(input logic [7:0] c, input bit rdy, input bit force_en, input bit force_h);
        bit h;
        h = is_dig(c) && gen_letter;
        if (force_en) h = force_h;
        if (is_let(c)) gen_letter = 1'b1;
        else if (!is_dig(c)) gen_letter = 1'b0;
        char_s    = c;
        id_hit    = prev_h;
        out_ready = rdy;
        @(posedge clk);
        process_pair(prev_c, prev_h, rdy);
        prev_c = c;
        prev_h = h;
        #1;
    endtask

    task automatic send(input string s, input bit rdy);
        for (int i = 0; i < s.len(); i++) step(s[i], rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(8'h00, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        char_s    = 8'h00;
        id_hit    = 1'b0;
        out_ready = 1'b0;
        occ = 0; exp_q.delete(); seg_q.delete();
        m_tok = 0; m_drop = 0; m_ovf = 1'b0; m_err = 1'b0;
        prev_c = 8'h00; prev_h = 1'b0; gen_letter = 1'b0; pops = 0;
        @(negedge clk);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_len", {24'd0, out_len}, 32'd0);
        check("rst out_digits", {24'd0, out_digits}, 32'd0);
        check("rst tok_count", {16'd0, tok_count}, 32'd0);
        check("rst drop_count", {24'd0, drop_count}, 32'd0);
        check("rst overflow", {31'd0, overflow}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares state against the model and consumes handshaken records
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            check("tok_count", {16'd0, tok_count}, m_tok);
            check("drop_count", {24'd0, drop_count}, m_drop);
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("err", {31'd0, err}, {31'd0, m_err});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected record: len %0d digits %0d, expected none", out_len, out_digits);
                end else begin
                    check("out_len", {24'd0, out_len}, exp_q[0].len);
                    check("out_digits", {24'd0, out_digits}, exp_q[0].dig);
                    void'(exp_q.pop_front());
                end
                last_len = out_len;
                last_dig = out_digits;
                pops++;
            end
        end
    end

    initial begin
        logic [7:0] c;
        int         r;
        bit         rdy;

        // "ab12 " -> one record {4,2}
        do_reset();
        send("ab12 ", 1'b1);
        idle(3, 1'b1);
        check("ab12 len", last_len, 32'd4);
        check("ab12 digits", last_dig, 32'd2);
        check("ab12 tok", {16'd0, tok_count}, 32'd1);
        check("ab12 pops", pops, 32'd1);

        // leading digits excluded
        do_reset();
        send("12ab3;", 1'b1);
        idle(3, 1'b1);
        check("12ab3 len", last_len, 32'd3);
        check("12ab3 digits", last_dig, 32'd1);

        // five tokens into a stalled FIFO of four
        do_reset();
        send("a b c d e ", 1'b0);
        idle(2, 1'b0);
        check("ovf drop_count", {24'd0, drop_count}, 32'd1);
        check("ovf overflow", {31'd0, overflow}, 32'd1);
        check("ovf tok_count", {16'd0, tok_count}, 32'd5);
        idle(8, 1'b1);
        check("ovf drained", pops, 32'd4);

        // full FIFO with push and pop on the same edge
        do_reset();
        send("a b c d ", 1'b0);
        idle(1, 1'b0);
        send("e ", 1'b0);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("full pp drop_count", {24'd0, drop_count}, 32'd0);
        check("full pp valid", {31'd0, out_valid}, 32'd1);
        idle(8, 1'b1);
        check("full pp drained", pops, 32'd5);

        // saturation
        do_reset();
        for (int i = 0; i < 300; i++) step("z", 1'b1, 1'b0, 1'b0);
        send(" ", 1'b1);
        idle(3, 1'b1);
        check("sat len", last_len, 32'd255);
        check("sat digits", last_dig, 32'd0);

        // cross-check: '7' inside an identifier without id_hit
        do_reset();
        step("x", 1'b1, 1'b0, 1'b0);
        step("7", 1'b1, 1'b1, 1'b0);
        step(" ", 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
`ifdef ID_TOKEN_CHECK_EN
        check("x7 err", {31'd0, err}, 32'd1);
`else
        check("x7 err", {31'd0, err}, 32'd0);
`endif
        check("x7 digits", last_dig, 32'd0);

        // reset in the middle of a token aborts it
        do_reset();
        send("abc", 1'b1);
        do_reset();
        send(" ", 1'b1);
        idle(3, 1'b1);
        check("abort pops", pops, 32'd0);
        check("abort tok", {16'd0, tok_count}, 32'd0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      c = (($urandom_range(0, 1) != 0) ? 8'h41 : 8'h61) + 8'($urandom_range(0, 25));
            else if (r < 7) c = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 9) c = 8'h20;
            else            c = 8'($urandom_range(0, 255));
            rdy = ((i / 200) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step(c, rdy, 1'b0, 1'b0);
        end
        idle(12, 1'b1);
        check("random drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
